// File: rtl/myproject_mac_pkg.sv
// Shared constants and helpers for the multiply-accumulate pipeline.
package myproject_mac_pkg;

   localparam int unsigned NUM_STAGE_MIN = 1;
   localparam int unsigned NUM_STAGE_MAX = 4;
   localparam int unsigned ACC_LEN_MIN   = 1;
   localparam int unsigned ACC_LEN_MAX   = 1024;

   // Group counter width; a one-product group still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned acc_len);
      return (acc_len <= 2) ? 1 : $clog2(acc_len);
   endfunction

   function automatic int unsigned clamp_range(input int unsigned val,
                                               input int unsigned lo,
                                               input int unsigned hi);
      return (val < lo) ? lo : ((val > hi) ? hi : val);
   endfunction

endpackage

// File: rtl/myproject_mul_pipe.sv
// Unsigned x signed product, sign-extended to the accumulator width and
// carried through NUM_STAGE clock-enabled registers with its valid.
module myproject_mul_pipe #(
   parameter int unsigned DIN0_WIDTH = 12,
   parameter int unsigned DIN1_WIDTH = 8,
   parameter int unsigned DOUT_WIDTH = 24,
   parameter int unsigned NUM_STAGE  = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  in_vld,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic [DOUT_WIDTH-1:0] prod,
   output logic                  prod_vld
);

   localparam int unsigned PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH + 1;

   logic signed [PROD_WIDTH-1:0] op0_c;
   logic signed [PROD_WIDTH-1:0] op1_c;
   logic signed [PROD_WIDTH-1:0] prod_c;
   logic        [DOUT_WIDTH-1:0] prod_ext_c;

   logic [DOUT_WIDTH-1:0] data_q [NUM_STAGE];
   logic                  vld_q  [NUM_STAGE];

   // din0 is zero-extended (unsigned), din1 sign-extended before multiplying.
   assign op0_c      = PROD_WIDTH'($signed({1'b0, din0}));
   assign op1_c      = PROD_WIDTH'($signed(din1));
   assign prod_c     = op0_c * op1_c;
   assign prod_ext_c = DOUT_WIDTH'(prod_c);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         for (int i = 0; i < int'(NUM_STAGE); i++) begin
            data_q[i] <= '0;
            vld_q[i]  <= 1'b0;
         end
      end else if (ce) begin
         data_q[0] <= prod_ext_c;
         vld_q[0]  <= in_vld;
         for (int i = 1; i < int'(NUM_STAGE); i++) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
      end
   end

   assign prod     = data_q[NUM_STAGE-1];
   assign prod_vld = vld_q[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply-accumulate: sums ACC_LEN products per output strobe.
// Define MYPROJECT_MAC_SAT_EN to saturate the accumulator instead of wrapping.
module myproject_mac_pipe
   import myproject_mac_pkg::*;
#(
   parameter int unsigned DIN0_WIDTH = 12,
   parameter int unsigned DIN1_WIDTH = 8,
   parameter int unsigned DOUT_WIDTH = 24,
   parameter int unsigned NUM_STAGE  = 2,
   parameter int unsigned ACC_LEN    = 8
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  in_vld,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  ovf
);

   localparam int unsigned STAGES    = clamp_range(NUM_STAGE, NUM_STAGE_MIN, NUM_STAGE_MAX);
   localparam int unsigned GROUP_LEN = clamp_range(ACC_LEN, ACC_LEN_MIN, ACC_LEN_MAX);
   localparam int unsigned CNT_WIDTH = cnt_width(GROUP_LEN);
   localparam int unsigned MSB       = DOUT_WIDTH - 1;

   logic [DOUT_WIDTH-1:0] prod;
   logic                  prod_vld;

   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [DOUT_WIDTH-1:0] acc_q;
   logic                  ovf_q;
   logic                  strobe_q;

   logic                  first_c;
   logic                  last_c;
   logic [DOUT_WIDTH-1:0] sum_c;
   logic                  sum_ovf_c;
   logic [DOUT_WIDTH-1:0] acc_nxt_c;
   logic                  ovf_nxt_c;

   myproject_mul_pipe #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .NUM_STAGE  (STAGES)
   ) u_mul_pipe (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .ce       (ce),
      .in_vld   (in_vld),
      .din0     (din0),
      .din1     (din1),
      .prod     (prod),
      .prod_vld (prod_vld)
   );

   // Next accumulator value and sticky overflow for the product at the pipe end.
   always_comb begin
      first_c   = (cnt_q == '0);
      last_c    = (cnt_q == CNT_WIDTH'(GROUP_LEN - 1));
      sum_c     = acc_q + prod;
      sum_ovf_c = (acc_q[MSB] == prod[MSB]) && (sum_c[MSB] != acc_q[MSB]);
      acc_nxt_c = sum_c;
      ovf_nxt_c = ovf_q | sum_ovf_c;
`ifdef MYPROJECT_MAC_SAT_EN
      if (sum_ovf_c) begin
         acc_nxt_c = acc_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
`endif
      if (first_c) begin
         acc_nxt_c = prod;
         ovf_nxt_c = 1'b0;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         strobe_q <= 1'b0;
         dout     <= '0;
      end else if (ce) begin
         strobe_q <= 1'b0;
         if (prod_vld) begin
            acc_q <= acc_nxt_c;
            ovf_q <= ovf_nxt_c;
            cnt_q <= last_c ? '0 : cnt_q + CNT_WIDTH'(1);
            if (last_c) begin
               dout     <= acc_nxt_c;
               strobe_q <= 1'b1;
            end
         end
      end
   end

   // A strobe held across ce=0 cycles is shown only in the next enabled cycle.
   assign dout_vld = strobe_q & ce;
   assign ovf      = ovf_q;

endmodule
